// File: rtl/sign_mult_pkg.sv
// -----------------------------------------------------------------------------
// sign_mult_pkg
// Shared constants and types for the sign_mult_acc block.
//   PROD_W    : width of each signed product coming from the multipliers
//   DEF_CNT_N : default number of products summed per batch
//   DEF_ACC_W : default accumulator / result width
//   state_t   : batch FSM states (ACCUM collects beats, HOLD presents result)
// -----------------------------------------------------------------------------
package sign_mult_pkg;

    localparam int PROD_W    = 16;
    localparam int DEF_CNT_N = 8;
    localparam int DEF_ACC_W = 20;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/sign_mult_sat_add.sv
// -----------------------------------------------------------------------------
// sign_mult_sat_add
// Combinational signed adder that clamps to the representable ACC_W range
// instead of wrapping.
// Ports:
//   i_a   : signed accumulator operand (ACC_W bits)
//   i_b   : signed addend, already sign-extended to ACC_W bits
//   o_sum : clamped sum (ACC_W bits)
//   o_sat : 1 when the true sum fell outside the range and was clamped
// -----------------------------------------------------------------------------
module sign_mult_sat_add
    import sign_mult_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_sat
);

    localparam logic [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_wide;

    // One guard bit: the true sum of two ACC_W-bit values always fits in
    // ACC_W+1 bits, so overflow shows up as the top two bits disagreeing.
    assign w_wide = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};

    // The guard bit carries the true sign, which picks the clamp direction.
    always_comb begin
        o_sum = w_wide[ACC_W-1:0];
        o_sat = 1'b0;
        if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
            o_sat = 1'b1;
            o_sum = w_wide[ACC_W] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/sign_mult_acc.sv
// -----------------------------------------------------------------------------
// sign_mult_acc
// Sums CNT_N signed products (z1) per batch while cross-checking a duplicate
// multiplier output (z2). The finished batch is held on the output until the
// consumer takes it.
// Optional feature: define SIGN_MULT_ACC_SAT_EN to clamp every addition and
// report clamping on out_sat; otherwise additions wrap and out_sat is 0.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : synchronous batch abort (drops the beat and any result)
//   in_valid      : product pair presented on z1/z2
//   in_ready      : block accepts a pair this cycle (ACCUM state only)
//   z1, z2        : signed products from the two multipliers
//   out_valid     : batch result held stable (HOLD state)
//   out_ready     : consumer takes the result
//   out_sum       : running sum in ACCUM, batch result in HOLD
//   out_mismatch  : z1 != z2 was seen on an accepted beat of this batch
//   out_sat       : a clamp happened in this batch (0 without the feature)
// -----------------------------------------------------------------------------
module sign_mult_acc
    import sign_mult_pkg::*;
#(
    parameter int CNT_N = DEF_CNT_N,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] z1,
    input  logic signed [PROD_W-1:0] z2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_mismatch,
    output logic                     out_sat
);

    localparam int               CNT_W    = $clog2(CNT_N + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CNT_N - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_live;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_mismatch;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_release;
    logic signed [ACC_W-1:0]  w_z1_ext;
    logic signed [ACC_W-1:0]  w_sum;

    // r_live keeps in_ready low during reset and on the first edge after
    // release, so a beat offered on that edge is never taken.
    assign in_ready  = r_live && (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready && !clr;
    assign w_last    = w_accept && (r_cnt == LAST_IDX);
    assign w_release = out_valid && out_ready;

    assign w_z1_ext     = ACC_W'(signed'(z1));
    assign out_sum      = r_acc;
    assign out_mismatch = r_mismatch;

`ifdef SIGN_MULT_ACC_SAT_EN
    logic w_sat;
    logic r_sat;

    sign_mult_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_z1_ext),
        .o_sum (w_sum),
        .o_sat (w_sat)
    );

    assign out_sat = r_sat;

    // Sticky clamp flag, cleared together with the rest of the batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (clr || w_release) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= r_sat | w_sat;
        end
    end
`else
    assign w_sum   = r_acc + w_z1_ext;
    assign out_sat = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: clr wins everywhere; ACCUM leaves on the last beat of the
    // batch, HOLD leaves once the consumer has taken the result.
    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_last)    w_next_state = HOLD;
                HOLD:    if (out_ready) w_next_state = ACCUM;
                default: w_next_state = ACCUM;
            endcase
        end
    end

    // Batch datapath: an abort or a completed handshake starts a fresh batch;
    // otherwise each accepted beat is folded into the sum. The counter stops
    // at CNT_N because HOLD blocks further beats, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (clr || w_release) begin
                r_cnt      <= '0;
                r_acc      <= '0;
                r_mismatch <= 1'b0;
            end else if (w_accept) begin
                r_cnt      <= r_cnt + 1'b1;
                r_acc      <= w_sum;
                r_mismatch <= r_mismatch | (z1 != z2);
            end
        end
    end

endmodule

// File: tb/tb_sign_mult_acc.sv
// -----------------------------------------------------------------------------
// tb_sign_mult_acc
// Drives two instances of sign_mult_acc from shared inputs: A uses the default
// sizes (CNT_N=8, ACC_W=20), B a short narrow batch (CNT_N=4, ACC_W=16).
// Expected behaviour comes from a per-instance batch model (list-free running
// sum with wrap or clamp arithmetic) plus hand-derived constants.
// -----------------------------------------------------------------------------
module tb_sign_mult_acc;

    localparam int CNT_A = 8;
    localparam int ACC_A = 20;
    localparam int CNT_B = 4;
    localparam int ACC_B = 16;

`ifdef SIGN_MULT_ACC_SAT_EN
    localparam longint EXP_SAT_SUM = 32767;
    localparam longint EXP_SAT_FLAG = 1;
`else
    localparam longint EXP_SAT_SUM = 0;
    localparam longint EXP_SAT_FLAG = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic inValid;
    logic outReady;
    logic signed [15:0] z1;
    logic signed [15:0] z2;

    logic rdyA, valA, misA, satA;
    logic signed [ACC_A-1:0] sumA;
    logic rdyB, valB, misB, satB;
    logic signed [ACC_B-1:0] sumB;

    sign_mult_acc #(.CNT_N(CNT_A), .ACC_W(ACC_A)) dutA (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(rdyA),
        .z1(z1), .z2(z2), .out_valid(valA), .out_ready(outReady),
        .out_sum(sumA), .out_mismatch(misA), .out_sat(satA)
    );

    sign_mult_acc #(.CNT_N(CNT_B), .ACC_W(ACC_B)) dutB (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(rdyB),
        .z1(z1), .z2(z2), .out_valid(valB), .out_ready(outReady),
        .out_sum(sumB), .out_mismatch(misB), .out_sat(satB)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    // Model state per instance (0 = A, 1 = B).
    bit     mLive[2];
    bit     mHold[2];
    bit     mMis[2];
    bit     mSat[2];
    int     mCnt[2];
    longint mSum[2];
    int     cntN[2];
    int     accW[2];

    typedef struct {
        bit v;
        bit c;
        bit r;
        int a;
        int b;
        bit eRdy;
        bit eVal;
        int eSum;
        bit eMis;
    } vec_t;

    vec_t tbl[$];

    function automatic longint wrapTo(longint v, int w);
        longint m;
        longint r;
        m = longint'(1) <<< w;
        r = v % m;
        if (r < 0) r = r + m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    task automatic compare(string name, longint act, longint exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic clearBatch(int i);
        mHold[i] = 1'b0;
        mCnt[i]  = 0;
        mSum[i]  = 0;
        mMis[i]  = 1'b0;
        mSat[i]  = 1'b0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mLive[i] = 1'b0;
            clearBatch(i);
        end
    endtask

    // One rising edge as seen by the batch rules, using the inputs held
    // across that edge.
    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            bit     take;
            longint s;
            longint hi;
            longint lo;
            take = mLive[i] && !mHold[i] && inValid && !clr;
            hi = (longint'(1) <<< (accW[i] - 1)) - 1;
            lo = -(longint'(1) <<< (accW[i] - 1));
            if (clr) begin
                clearBatch(i);
            end else if (mHold[i] && outReady) begin
                clearBatch(i);
            end else if (take) begin
                s = mSum[i] + longint'(z1);
`ifdef SIGN_MULT_ACC_SAT_EN
                if (s > hi) begin s = hi; mSat[i] = 1'b1; end
                if (s < lo) begin s = lo; mSat[i] = 1'b1; end
`else
                s = wrapTo(s, accW[i]);
`endif
                mSum[i] = s;
                mCnt[i]++;
                if (z1 != z2) mMis[i] = 1'b1;
                if (mCnt[i] == cntN[i]) mHold[i] = 1'b1;
            end
            mLive[i] = 1'b1;
        end
    endtask

    task automatic checkOutput();
        compare("A.in_ready",     longint'(rdyA), longint'(mLive[0] && !mHold[0]));
        compare("A.out_valid",    longint'(valA), longint'(mHold[0]));
        compare("A.out_sum",      longint'(sumA), mSum[0]);
        compare("A.out_mismatch", longint'(misA), longint'(mMis[0]));
        compare("A.out_sat",      longint'(satA), longint'(mSat[0]));
        compare("B.in_ready",     longint'(rdyB), longint'(mLive[1] && !mHold[1]));
        compare("B.out_valid",    longint'(valB), longint'(mHold[1]));
        compare("B.out_sum",      longint'(sumB), mSum[1]);
        compare("B.out_mismatch", longint'(misB), longint'(mMis[1]));
        compare("B.out_sat",      longint'(satB), longint'(mSat[1]));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then check
    // at the next falling edge.
    task automatic applyStimulus(bit v, bit c, bit r, int a, int b);
        inValid  = v;
        clr      = c;
        outReady = r;
        z1       = 16'(a);
        z2       = 16'(b);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    // Asynchronous reset pulse between edges; outputs must drop at once.
    task automatic pulseReset();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        compare("rst.A.out_sum",  longint'(sumA), 0);
        compare("rst.B.in_ready", longint'(rdyB), 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
    endtask

    task automatic addVec(bit v, bit c, bit r, int a, int b,
                          bit eRdy, bit eVal, int eSum, bit eMis);
        vec_t t;
        t.v = v; t.c = c; t.r = r; t.a = a; t.b = b;
        t.eRdy = eRdy; t.eVal = eVal; t.eSum = eSum; t.eMis = eMis;
        tbl.push_back(t);
    endtask

    initial begin
        cntN[0] = CNT_A; accW[0] = ACC_A;
        cntN[1] = CNT_B; accW[1] = ACC_B;
        rst_n = 1'b0; clr = 1'b0; inValid = 1'b0; outReady = 1'b0;
        z1 = '0; z2 = '0;
        modelReset();

        #3;
        checkOutput();
        compare("reset.A.in_ready",  longint'(rdyA), 0);
        compare("reset.B.out_valid", longint'(valB), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors; expectations refer to instance B (CNT_N=4).
        addVec(1'b1, 1'b0, 1'b0,  100, 100, 1'b1, 1'b0, 0, 1'b0); // first edge after reset: dropped
        addVec(1'b0, 1'b1, 1'b0,    0,   0, 1'b1, 1'b0, 0, 1'b0);
        addVec(1'b1, 1'b0, 1'b0,   -1,  -1, 1'b1, 1'b0, -1, 1'b0);
        addVec(1'b1, 1'b0, 1'b0,    2,   2, 1'b1, 1'b0, 1, 1'b0);
        addVec(1'b1, 1'b0, 1'b0,   -3,  -3, 1'b1, 1'b0, -2, 1'b0);
        addVec(1'b1, 1'b0, 1'b0,    4,   4, 1'b0, 1'b1, 2, 1'b0);
        addVec(1'b1, 1'b0, 1'b0,    7,   7, 1'b0, 1'b1, 2, 1'b0);
        addVec(1'b0, 1'b0, 1'b1,    0,   0, 1'b1, 1'b0, 0, 1'b0);
        addVec(1'b1, 1'b0, 1'b0,   -1,   5, 1'b1, 1'b0, -1, 1'b1);
        addVec(1'b1, 1'b0, 1'b0,    2,   2, 1'b1, 1'b0, 1, 1'b1);
        addVec(1'b1, 1'b0, 1'b0,   -3,  -3, 1'b1, 1'b0, -2, 1'b1);
        addVec(1'b1, 1'b0, 1'b0,    4,   4, 1'b0, 1'b1, 2, 1'b1);
        addVec(1'b0, 1'b0, 1'b1,    0,   0, 1'b1, 1'b0, 0, 1'b0);
        addVec(1'b1, 1'b1, 1'b0,    9,   9, 1'b1, 1'b0, 0, 1'b0); // beat with clr dropped
        addVec(1'b1, 1'b0, 1'b1,    5,   5, 1'b1, 1'b0, 5, 1'b0); // out_ready ignored in ACCUM
        addVec(1'b0, 1'b1, 1'b0,    0,   0, 1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].v, tbl[i].c, tbl[i].r, tbl[i].a, tbl[i].b);
            compare($sformatf("vec%0d.in_ready", i),  longint'(rdyB), longint'(tbl[i].eRdy));
            compare($sformatf("vec%0d.out_valid", i), longint'(valB), longint'(tbl[i].eVal));
            compare($sformatf("vec%0d.out_sum", i),   longint'(sumB), longint'(tbl[i].eSum));
            compare($sformatf("vec%0d.mismatch", i),  longint'(misB), longint'(tbl[i].eMis));
        end

        // Result held for five cycles with in_valid high and no consumer.
        applyStimulus(1'b1, 1'b0, 1'b0, 10, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 20, 20);
        applyStimulus(1'b1, 1'b0, 1'b0, 30, 30);
        applyStimulus(1'b1, 1'b0, 1'b0, 40, 40);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 77, 77);
            compare("hold.in_ready",  longint'(rdyB), 0);
            compare("hold.out_valid", longint'(valB), 1);
            compare("hold.out_sum",   longint'(sumB), 100);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 77, 77);
        compare("release.in_ready", longint'(rdyB), 1);
        compare("release.out_sum",  longint'(sumB), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 77, 77);
        compare("release.next_sum", longint'(sumB), 77);

        // Abort on the third beat, then a clean batch.
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1000, 1000);
        applyStimulus(1'b1, 1'b0, 1'b0, 2000, 2000);
        applyStimulus(1'b1, 1'b1, 1'b0, 5000, 5000);
        compare("clr.out_sum", longint'(sumB), 0);
        for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, k, k);
        compare("clr.batch_valid", longint'(valB), 1);
        compare("clr.batch_sum",   longint'(sumB), 10);

        // 16384 x 8: B overflows its 16-bit range, A sums to 131072.
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16384, 16384);
            if (k == 4) begin
                compare("ovf.B.out_valid", longint'(valB), 1);
                compare("ovf.B.out_sum",   longint'(sumB), EXP_SAT_SUM);
                compare("ovf.B.out_sat",   longint'(satB), EXP_SAT_FLAG);
            end
            if (k == 7) compare("big.A.early_valid", longint'(valA), 0);
        end
        compare("big.A.out_valid", longint'(valA), 1);
        compare("big.A.out_sum",   longint'(sumA), 131072);
        compare("big.A.mismatch",  longint'(misA), 0);
        compare("big.A.out_sat",   longint'(satA), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);

        // Reset mid-batch, then in HOLD.
        applyStimulus(1'b1, 1'b0, 1'b0, 500, 500);
        applyStimulus(1'b1, 1'b0, 1'b0, 500, 500);
        pulseReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 7, 7);
        compare("postrst.first_sum", longint'(sumB), 0);
        compare("postrst.in_ready",  longint'(rdyB), 1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1, 1);
        compare("postrst.out_valid", longint'(valB), 1);
        compare("postrst.out_sum",   longint'(sumB), 4);
        pulseReset();
        compare("rsthold.out_valid", longint'(valB), 0);
        compare("rsthold.out_sum",   longint'(sumB), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit v;
            bit c;
            bit r;
            int a;
            int b;
            if (n == 250) pulseReset();
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(15) == 0);
            r = ($urandom_range(1) == 1);
            a = int'($urandom_range(65535)) - 32768;
            b = ($urandom_range(7) == 0) ? int'($urandom_range(65535)) - 32768 : a;
            applyStimulus(v, c, r, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sign_mult_acc.md
SIGN_MULT_ACC -- requirements
Module: sign_mult_acc

Interface
REQ-001 Parameter CNT_N, default 8: number of products summed per batch; legal range 2..256.
REQ-002 Parameter ACC_W, default 20: accumulator and result width in bits; legal range 16..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clr  input  1  synchronous batch abort.
REQ-006 in_valid  input  1  a product pair is presented.
REQ-007 in_ready  output  1  the block accepts a pair this cycle.
REQ-008 z1  input  16  signed product from the first multiplier.
REQ-009 z2  input  16  signed product of the same operands from the second multiplier.
REQ-010 out_valid  output  1  batch result held stable.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  ACC_W  signed sum of CNT_N accepted z1 values.
REQ-013 out_mismatch  output  1  set when z1 != z2 on any accepted beat of the batch.
REQ-014 out_sat  output  1  saturation occurred in the batch; tied 0 when the SAT feature is compiled out.

Function
REQ-015 The FSM SHALL have exactly two states: ACCUM and HOLD.
REQ-016 in_ready SHALL be 1 in ACCUM and 0 in HOLD.
REQ-017 A beat is accepted iff in_valid and in_ready are both 1 and clr is 0.
REQ-018 On an accepted beat:
- acc <= acc + sign_extend(z1) to ACC_W bits;
- cnt increments;
- mismatch |= (z1 != z2).
REQ-019 When the CNT_N-th beat is accepted, the next state SHALL be HOLD, and out_valid SHALL be 1 in the following cycle with out_sum including that beat (latency 1 cycle).
REQ-020 In HOLD, out_sum, out_mismatch and out_sat SHALL stay stable until out_valid && out_ready.
REQ-021 On handshake in HOLD:
- next cycle: state ACCUM, acc=0, cnt=0, flags=0, out_valid=0;
- in_ready returns to 1 that same next cycle.
REQ-022 out_ready SHALL be ignored while out_valid is 0.
REQ-023 clr=1 in any state:
- next cycle: ACCUM, acc/cnt/flags cleared, out_valid=0;
- a beat presented with clr is dropped;
- a held result is discarded.
REQ-024 The counter SHALL be $clog2(CNT_N+1) bits and never wrap within a batch.
REQ-025 In ACCUM, out_valid SHALL be 0; out_sum SHALL show the running accumulator.

Reset
REQ-026 While rst_n=0, outputs SHALL be:
- in_ready=0, out_valid=0;
- out_sum=0, out_mismatch=0, out_sat=0;
- state=ACCUM, cnt=0.
REQ-027 The first clock edge after rst_n deasserts SHALL set in_ready=1; a beat offered on that edge SHALL NOT be accepted.
REQ-028 Reset asserted mid-batch or in HOLD SHALL discard all partial or held data immediately (asynchronously).

Configuration
REQ-029 With macro SIGN_MULT_ACC_SAT_EN defined:
- each addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
- out_sat sets sticky on any clamp within the batch.
REQ-030 Without SIGN_MULT_ACC_SAT_EN:
- addition wraps modulo 2^ACC_W;
- out_sat is constant 0.

Structure
REQ-031 Package sign_mult_pkg SHALL hold:
- PROD_W=16;
- the FSM state enum (ACCUM, HOLD);
- default CNT_N and ACC_W constants.
REQ-032 The optional saturating adder SHALL be a sub-module named sign_mult_sat_add; it is combinational and parameterised by ACC_W.

Verification
REQ-033 CNT_N=8, ACC_W=20, z1=z2=16384 for 8 beats -> out_valid one cycle after the 8th accept, out_sum=131072, mismatch=0, sat=0.
REQ-034 CNT_N=4, beats z1=z2 of -1, 2, -3, 4 -> out_sum=2; on one beat set z2 != z1 -> out_mismatch=1, sum unchanged.
REQ-035 Hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no beat consumed; then out_ready=1 -> in_ready=1 the next cycle.
REQ-036 clr asserted on the 3rd beat with in_valid=1, CNT_N=4 -> that beat dropped; the next 4 accepted beats form a batch whose sum excludes all prior beats.
REQ-037 ACC_W=16, CNT_N=4, z1=16384 x4:
- with SIGN_MULT_ACC_SAT_EN -> out_sum=32767, out_sat=1;
- without it -> out_sum=0, out_sat=0.
REQ-038 rst_n pulsed low mid-batch and in HOLD -> outputs immediately at reset values; the next batch sums only post-reset beats.
